bcd_digit_scanner: RTL and testbench

BCD_DIGIT_SCANNER -- requirements
Module: bcd_digit_scanner

---
 rtl/bcd_scan_pkg.sv | 17 +
 rtl/bcd_seg_decoder.sv | 23 ++
 rtl/bcd_digit_scanner.sv | 92 +++++++++
 tb/tb_bcd_digit_scanner.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/bcd_scan_pkg.sv
// bcd_scan_pkg: scanner FSM states, segment width and seven-segment patterns {g,f,e,d,c,b,a}.
package bcd_scan_pkg;
  localparam int SEG_W = 7;
  typedef enum logic {ST_GAP, ST_SCAN} scan_state_e;
  localparam logic [SEG_W-1:0] SEG_0    = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1    = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2    = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3    = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4    = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5    = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6    = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7    = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8    = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9    = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_DASH = 7'h40;
  localparam logic [SEG_W-1:0] SEG_OFF  = 7'h00;
endpackage

// File: rtl/bcd_seg_decoder.sv
// bcd_seg_decoder: combinational BCD nibble to seven-segment decode; non-decimal codes show a dash.
module bcd_seg_decoder
  import bcd_scan_pkg::*;
(
  input  logic [3:0]       bcd_i,
  output logic [SEG_W-1:0] seg_o
);
  always_comb begin
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/bcd_digit_scanner.sv
// bcd_digit_scanner: multiplexed BCD display scanner with blanking gaps and frame-aligned updates.
// Define BCD_SCAN_LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module bcd_digit_scanner
  import bcd_scan_pkg::*;
#(
  parameter int BCD_DIGITS       = 3,
  parameter int CLOCKS_PER_DIGIT = 4,
  parameter int GAP_CLOCKS       = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BCD_DIGITS*4-1:0] bcd,
  input  logic                    updated,
  output logic [BCD_DIGITS-1:0]   digit_sel,
  output logic [SEG_W-1:0]        seg,
  output logic                    frame_done
);
  localparam int CNT_MAX = CLOCKS_PER_DIGIT > GAP_CLOCKS ? CLOCKS_PER_DIGIT : GAP_CLOCKS;
  localparam int CNT_W = CNT_MAX > 1 ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W = BCD_DIGITS > 1 ? $clog2(BCD_DIGITS) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(CLOCKS_PER_DIGIT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CLOCKS > 0 ? GAP_CLOCKS - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BCD_DIGITS - 1);
  localparam scan_state_e ST_RST = GAP_CLOCKS > 0 ? ST_GAP : ST_SCAN;
  scan_state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BCD_DIGITS*4-1:0] disp_q, disp_d, pend_q, pend_d;
  logic pflag_q, pflag_d;
  logic [BCD_DIGITS-1:0] digit_sel_q;
  logic [SEG_W-1:0] seg_q, dec_seg;
  logic frame_done_q, scan_end, gap_end, wrap, blank;
  logic [3:0] nib;
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
  logic hz;
`endif
  // Outputs are registered from next-state values so they line up with the FSM state.
  always_comb begin
    scan_end = state_q == ST_SCAN && cnt_q == SCAN_LAST;
    gap_end = state_q == ST_GAP && cnt_q == GAP_LAST;
    wrap = scan_end && idx_q == IDX_LAST;
    state_d = scan_end ? (GAP_CLOCKS > 0 ? ST_GAP : ST_SCAN) : gap_end ? ST_SCAN : state_q;
    cnt_d = (scan_end || gap_end) ? '0 : cnt_q + 1'b1;
    idx_d = wrap ? '0 : scan_end ? idx_q + 1'b1 : idx_q;
    disp_d = wrap ? (updated ? bcd : pflag_q ? pend_q : disp_q) : disp_q;
    pend_d = updated && !wrap ? bcd : pend_q;
    pflag_d = wrap ? 1'b0 : updated | pflag_q;
    nib = '0;
    for (int i = 0; i < BCD_DIGITS; i++)
      if (idx_d == IDX_W'(i)) nib = disp_d[i*4 +: 4];
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
    hz = 1'b1;
    blank = 1'b0;
    for (int i = BCD_DIGITS - 1; i > 0; i--) begin
      hz = hz && disp_d[i*4 +: 4] == 4'd0;
      blank = blank | (hz && idx_d == IDX_W'(i));
    end
`else
    blank = 1'b0;
`endif
  end
  bcd_seg_decoder u_dec (
    .bcd_i(nib),
    .seg_o(dec_seg)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RST;
      idx_q <= '0;
      cnt_q <= '0;
      disp_q <= '0;
      pend_q <= '0;
      pflag_q <= 1'b0;
      digit_sel_q <= '0;
      seg_q <= SEG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      disp_q <= disp_d;
      pend_q <= pend_d;
      pflag_q <= pflag_d;
      digit_sel_q <= state_d == ST_SCAN ? BCD_DIGITS'(1) << idx_d : '0;
      seg_q <= state_d == ST_SCAN && !blank ? dec_seg : SEG_OFF;
      frame_done_q <= wrap;
    end
  end
  assign digit_sel = digit_sel_q;
  assign seg = seg_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_bcd_digit_scanner.sv
// tb_bcd_digit_scanner: scoreboard bench; a frame-position model queues expected outputs per cycle.
module tb_bcd_digit_scanner;
  localparam int N = 3, CPD = 4, GAP = 1, SLOT = GAP + CPD, FRAME = N * SLOT;
  typedef struct packed {
    logic [2:0] sel;
    logic [6:0] seg;
    logic       fd;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, updated = 1'b0;
  logic [11:0] bcd = '0;
  logic [2:0] digit_sel;
  logic [6:0] seg;
  logic frame_done;
  exp_t sb[$];
  int n_vec = 0, n_err = 0, t = 0;
  logic [11:0] disp_m = '0, pend_m = '0;
  logic pflag_m = 1'b0;
  always #5 clk = ~clk;
  bcd_digit_scanner #(.BCD_DIGITS(N), .CLOCKS_PER_DIGIT(CPD), .GAP_CLOCKS(GAP)) dut (
    .clk(clk),
    .rst(rst),
    .bcd(bcd),
    .updated(updated),
    .digit_sel(digit_sel),
    .seg(seg),
    .frame_done(frame_done)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, t);
    end
  endtask
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction
  function automatic exp_t expect_at(input int tt);
    exp_t e;
    int p, slot, sub;
    p = tt % FRAME;
    slot = p / SLOT;
    sub = p % SLOT;
    e.fd = tt > 0 && p == 0;
    e.sel = sub < GAP ? 3'b000 : 3'(1 << slot);
    e.seg = sub < GAP ? 7'h00 : seg_of(disp_m[slot*4 +: 4]);
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
    if (sub >= GAP && slot > 0 && (disp_m >> (4 * slot)) == 12'd0) e.seg = 7'h00;
`endif
    return e;
  endfunction
  task automatic cyc(input logic u, input logic [11:0] v);
    exp_t e;
    check("sb_depth", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("digit_sel", digit_sel, e.sel);
      check("seg", seg, e.seg);
      check("frame_done", frame_done, e.fd);
    end
    updated = u;
    bcd = v;
    if (t % FRAME == FRAME - 1) begin
      disp_m = u ? v : pflag_m ? pend_m : disp_m;
      pflag_m = 1'b0;
    end else if (u) begin
      pend_m = v;
      pflag_m = 1'b1;
    end
    t++;
    sb.push_back(expect_at(t));
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(1'b0, bcd);
  endtask
  task automatic run_to(input int p);
    for (int k = 0; k < FRAME && t % FRAME != p; k++) cyc(1'b0, bcd);
  endtask
  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
    t = 0;
    disp_m = '0;
    pend_m = '0;
    pflag_m = 1'b0;
    sb.delete();
    sb.push_back(expect_at(0));
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_sel", digit_sel, 0);
    check("rst_seg", seg, 0);
    check("rst_fd", frame_done, 0);
    release_rst();
    idle(2 * FRAME + 2);
    run_to(7);
    cyc(1'b1, 12'h127);
    idle(2 * FRAME);
    run_to(3);
    cyc(1'b1, 12'h111);
    run_to(9);
    cyc(1'b1, 12'h042);
    idle(FRAME + 6);
    run_to(FRAME - 1);
    cyc(1'b1, 12'h999);
    idle(FRAME);
    run_to(2);
    cyc(1'b1, 12'h0A5);
    idle(2 * FRAME);
    run_to(4);
    cyc(1'b1, 12'h007);
    idle(2 * FRAME);
    repeat (60) cyc($urandom_range(0, 3) == 0, 12'($urandom));
    idle(FRAME);
    run_to(8);
    #2 rst = 1'b1;
    #1;
    check("abort_sel", digit_sel, 0);
    check("abort_seg", seg, 0);
    check("abort_fd", frame_done, 0);
    repeat (3) begin
      @(negedge clk);
      check("held_fd", frame_done, 0);
      check("held_sel", digit_sel, 0);
    end
    release_rst();
    idle(2 * FRAME);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
